commit_port_sequencer: RTL and testbench

- Sits between the CVA6 commit ports and the trace FSM that builds iaddr/iretire/ilastsize packets.
- CVA6 can retire NR_PORTS instructions per cycle; the FSM consumes one `mure_pkg::fifo_entry_s` per cycle.
- This block buffers commit entries in program order and issues exactly one per cycle.
- It raises a stall request before its buffer fills and flags any entry lost to overflow.

---
 rtl/commit_port_sequencer.sv | 166 ++++++++++++++++
 tb/tb_commit_port_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_port_sequencer.sv
// ---------------------------------------------------------------------------
// commit_port_sequencer
//
// Purpose:
//   Serialises the CVA6 commit ports into the single-entry-per-cycle stream
//   that the trace packet FSM consumes.
//
//   - Up to NR_PORTS commit entries arrive each cycle. Port 0 is the oldest.
//   - They are buffered in program order.
//   - Exactly one entry is presented per cycle while the buffer holds data.
//   - A stall request is raised before the buffer can fill.
//   - Any entry that still cannot be stored is dropped, and a sticky overflow
//     flag records the loss.
//
// Ports:
//   clk_i         in   clock
//   rst_ni        in   asynchronous active-low reset
//   fifo_entry_i  in   NR_PORTS commit entries, index 0 oldest
//   enable_i      in   tracing enable; low blocks all pushes
//   flush_i       in   synchronous clear of pointers, count and overflow
//   fifo_entry_o  out  head entry, all-zero when the buffer is empty
//   stall_o       out  buffer nearly full (count >= DEPTH - NR_PORTS)
//   overflow_o    out  sticky: at least one live entry was dropped
//   count_o       out  current occupancy
// ---------------------------------------------------------------------------

package mure_pkg;

  localparam int unsigned XLEN = 64;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            compressed;
    logic [2:0]      itype;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic [1:0]      priv;
  } fifo_entry_s;

endpackage

module commit_port_sequencer
  import mure_pkg::*;
#(
  parameter int unsigned NR_PORTS = 2,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  fifo_entry_s [NR_PORTS-1:0]    fifo_entry_i,
  input  logic                          enable_i,
  input  logic                          flush_i,
  output fifo_entry_s                   fifo_entry_o,
  output logic                          stall_o,
  output logic                          overflow_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Storage and registered state
  fifo_entry_s   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  // Per-cycle push/pop decisions
  logic                pop;
  logic [NR_PORTS-1:0] live;
  logic [NR_PORTS-1:0] accept;
  logic [PW-1:0]       slot [NR_PORTS];
  logic [CW-1:0]       n_accepted;
  logic                dropped;
  logic [CW:0]         occ_after_pop;
  logic [CW:0]         live_rank;

  // There is no ready input: the head is consumed every cycle it is shown.
  assign pop = (count_q != '0);

  // Exceptions retire with valid=0 but itype=1, so they count as live too.
  always_comb begin
    live = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      live[i] = enable_i &&
                (fifo_entry_i[i].valid || (fifo_entry_i[i].itype == 3'd1));
    end
  end

  // Scan the live ports in ascending order and give each accepted one the
  // next free slot.
  //
  // - Dead ports are skipped, so the accepted entries stay contiguous.
  // - Space is measured after this cycle's pop.
  // - Once one live entry fails to fit, every later one fails as well.
  //   Because of that, n_accepted always equals the rank of the next
  //   accepted port.
  // - The occupancy math uses one spare bit so the sum cannot wrap.
  always_comb begin
    accept        = '0;
    dropped       = 1'b0;
    n_accepted    = '0;
    live_rank     = '0;
    occ_after_pop = {1'b0, count_q} - (CW+1)'(pop);
    for (int i = 0; i < NR_PORTS; i++) begin
      slot[i] = wr_ptr_q + PW'(n_accepted);
      if (live[i]) begin
        if ((occ_after_pop + live_rank) < (CW+1)'(DEPTH)) begin
          accept[i]  = 1'b1;
          n_accepted = n_accepted + CW'(1);
        end else begin
          dropped = 1'b1;
        end
        live_rank = live_rank + (CW+1)'(1);
      end
    end
  end

  // Entry storage has no reset. The output is masked to zero whenever
  // count_q is zero, so stale slot contents are never visible. A flush
  // discards this cycle's writes along with the pointers.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      for (int i = 0; i < NR_PORTS; i++) begin
        if (accept[i]) begin
          mem_q[slot[i]] <= fifo_entry_i[i];
        end
      end
    end
  end

  // Pointer, count and sticky overflow update.
  // - Flush clears everything and ignores this cycle's push and pop.
  // - The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      wr_ptr_q <= wr_ptr_q + PW'(n_accepted);
      count_q  <= count_q - CW'(pop) + n_accepted;
      if (dropped) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Downstream treats any nonzero itype as special even when valid=0.
  // The empty output must therefore be fully zero, not just invalid.
  assign fifo_entry_o = pop ? mem_q[rd_ptr_q] : '0;

  assign stall_o    = (count_q >= CW'(DEPTH - NR_PORTS));
  assign overflow_o = overflow_q;
  assign count_o    = count_q;

endmodule

// File: tb/tb_commit_port_sequencer.sv
// ---------------------------------------------------------------------------
// tb_commit_port_sequencer
//
// Directed testbench for commit_port_sequencer with NR_PORTS=2 and DEPTH=8.
//
// - Each scenario task drives its inputs and compares the DUT outputs
//   against hand-computed values.
// - Inputs are driven and outputs sampled 1 time unit after the rising
//   clock edge, away from the edge itself.
// ---------------------------------------------------------------------------
module tb_commit_port_sequencer;

  localparam int unsigned NR_PORTS = 2;
  localparam int unsigned DEPTH    = 8;

  logic                              clk_i;
  logic                              rst_ni;
  mure_pkg::fifo_entry_s [NR_PORTS-1:0] fifo_entry_i;
  logic                              enable_i;
  logic                              flush_i;
  mure_pkg::fifo_entry_s             fifo_entry_o;
  logic                              stall_o;
  logic                              overflow_o;
  logic [$clog2(DEPTH):0]            count_o;

  int checks;
  int failures;

  commit_port_sequencer #(
    .NR_PORTS(NR_PORTS),
    .DEPTH   (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .fifo_entry_i(fifo_entry_i),
    .enable_i    (enable_i),
    .flush_i     (flush_i),
    .fifo_entry_o(fifo_entry_o),
    .stall_o     (stall_o),
    .overflow_o  (overflow_o),
    .count_o     (count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Hard time limit so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    fifo_entry_i = '0;
  endtask

  function automatic mure_pkg::fifo_entry_s mk(logic v, logic [63:0] pc);
    mure_pkg::fifo_entry_s e;
    e       = '0;
    e.valid = v;
    e.pc    = pc;
    return e;
  endfunction

  task automatic test_reset();
    checks++;
    if (count_o !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_count: got %0d expected 0", count_o);
    end
    checks++;
    if (fifo_entry_o !== '0) begin
      failures++;
      $display("[TB] FAIL reset_entry: got %h expected 0", fifo_entry_o);
    end
    checks++;
    if (stall_o !== 1'b0 || overflow_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got stall=%b ovf=%b expected 0 0", stall_o, overflow_o);
    end
  endtask

  task automatic test_dual_issue();
    fifo_entry_i[0] = mk(1'b1, 64'h8000_0000);
    fifo_entry_i[0].compressed = 1'b1;
    fifo_entry_i[1] = mk(1'b1, 64'h8000_0004);
    tick();
    clear_inputs();
    checks++;
    if (fifo_entry_o.pc !== 64'h8000_0000 || fifo_entry_o.compressed !== 1'b1 || count_o !== 4'd2) begin
      failures++;
      $display("[TB] FAIL dual_k1: got pc=%h c=%b cnt=%0d expected pc=80000000 c=1 cnt=2",
               fifo_entry_o.pc, fifo_entry_o.compressed, count_o);
    end
    tick();
    checks++;
    if (fifo_entry_o.pc !== 64'h8000_0004 || fifo_entry_o.compressed !== 1'b0 || count_o !== 4'd1) begin
      failures++;
      $display("[TB] FAIL dual_k2: got pc=%h c=%b cnt=%0d expected pc=80000004 c=0 cnt=1",
               fifo_entry_o.pc, fifo_entry_o.compressed, count_o);
    end
    tick();
    checks++;
    if (fifo_entry_o !== '0 || count_o !== 4'd0) begin
      failures++;
      $display("[TB] FAIL dual_k3: got entry=%h cnt=%0d expected 0 0", fifo_entry_o, count_o);
    end
  endtask

  task automatic test_exception();
    fifo_entry_i[1]       = '0;
    fifo_entry_i[1].itype = 3'd1;
    fifo_entry_i[1].cause = 64'd2;
    fifo_entry_i[1].tval  = 64'hdead;
    tick();
    clear_inputs();
    checks++;
    if (fifo_entry_o.itype !== 3'd1 || fifo_entry_o.cause !== 64'd2 ||
        fifo_entry_o.tval !== 64'hdead || fifo_entry_o.valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL exc_k1: got itype=%0d cause=%h tval=%h v=%b expected 1 2 dead 0",
               fifo_entry_o.itype, fifo_entry_o.cause, fifo_entry_o.tval, fifo_entry_o.valid);
    end
    tick();
    checks++;
    if (fifo_entry_o !== '0) begin
      failures++;
      $display("[TB] FAIL exc_k2: got %h expected 0", fifo_entry_o);
    end
  endtask

  task automatic test_compaction();
    fifo_entry_i[0] = '0;
    fifo_entry_i[1] = mk(1'b1, 64'h100);
    tick();
    clear_inputs();
    checks++;
    if (fifo_entry_o.pc !== 64'h100 || fifo_entry_o.valid !== 1'b1 || count_o !== 4'd1) begin
      failures++;
      $display("[TB] FAIL compact_k1: got pc=%h v=%b cnt=%0d expected 100 1 1",
               fifo_entry_o.pc, fifo_entry_o.valid, count_o);
    end
    tick();
    checks++;
    if (fifo_entry_o !== '0 || count_o !== 4'd0) begin
      failures++;
      $display("[TB] FAIL compact_k2: got entry=%h cnt=%0d expected 0 0", fifo_entry_o, count_o);
    end
  endtask

  task automatic test_fill_overflow();
    logic [63:0] base;
    int          exp_cnt;
    base = 64'h1000;
    // Push pair t (pcs 2(t-1) and 2t-1) every cycle; head pops one per cycle
    for (int t = 1; t <= 8; t++) begin
      fifo_entry_i[0] = mk(1'b1, base + 64'(8 * (t - 1)));
      fifo_entry_i[1] = mk(1'b1, base + 64'(8 * (t - 1) + 4));
      tick();
      exp_cnt = (t == 1) ? 2 : ((t + 1 > 8) ? 8 : t + 1);
      checks++;
      if (count_o !== 4'(exp_cnt) || stall_o !== (exp_cnt >= 6) ||
          overflow_o !== (t == 8) || fifo_entry_o.pc !== base + 64'(4 * (t - 1))) begin
        failures++;
        $display("[TB] FAIL fill_%0d: got cnt=%0d stall=%b ovf=%b pc=%h expected cnt=%0d stall=%b ovf=%b pc=%h",
                 t, count_o, stall_o, overflow_o, fifo_entry_o.pc,
                 exp_cnt, (exp_cnt >= 6), (t == 8), base + 64'(4 * (t - 1)));
      end
    end
    clear_inputs();
    // Drain: entries 8..14 follow in order; entry 15 was the one dropped
    for (int t = 9; t <= 16; t++) begin
      tick();
      checks++;
      if (t < 16) begin
        if (count_o !== 4'(16 - t) || overflow_o !== 1'b1 ||
            fifo_entry_o.pc !== base + 64'(4 * (t - 1))) begin
          failures++;
          $display("[TB] FAIL drain_%0d: got cnt=%0d ovf=%b pc=%h expected cnt=%0d ovf=1 pc=%h",
                   t, count_o, overflow_o, fifo_entry_o.pc, 16 - t, base + 64'(4 * (t - 1)));
        end
      end else begin
        if (count_o !== 4'd0 || fifo_entry_o !== '0 || overflow_o !== 1'b1) begin
          failures++;
          $display("[TB] FAIL drain_end: got cnt=%0d entry=%h ovf=%b expected 0 0 1",
                   count_o, fifo_entry_o, overflow_o);
        end
      end
    end
  endtask

  task automatic test_flush();
    for (int p = 0; p < 4; p++) begin
      fifo_entry_i[0] = mk(1'b1, 64'h2000 + 64'(8 * p));
      fifo_entry_i[1] = mk(1'b1, 64'h2004 + 64'(8 * p));
      tick();
    end
    checks++;
    if (count_o !== 4'd5 || overflow_o !== 1'b1 || fifo_entry_o.pc !== 64'h200c) begin
      failures++;
      $display("[TB] FAIL flush_pre: got cnt=%0d ovf=%b pc=%h expected 5 1 200c",
               count_o, overflow_o, fifo_entry_o.pc);
    end
    flush_i = 1'b1;
    #1;
    checks++;
    if (fifo_entry_o.pc !== 64'h200c) begin
      failures++;
      $display("[TB] FAIL flush_cycle_head: got pc=%h expected 200c", fifo_entry_o.pc);
    end
    tick();
    flush_i = 1'b0;
    clear_inputs();
    checks++;
    if (count_o !== 4'd0 || overflow_o !== 1'b0 || fifo_entry_o !== '0 || stall_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_post: got cnt=%0d ovf=%b entry=%h stall=%b expected 0 0 0 0",
               count_o, overflow_o, fifo_entry_o, stall_o);
    end
    tick();
    checks++;
    if (count_o !== 4'd0 || fifo_entry_o !== '0) begin
      failures++;
      $display("[TB] FAIL flush_after: got cnt=%0d entry=%h expected 0 0", count_o, fifo_entry_o);
    end
  endtask

  task automatic test_disable();
    fifo_entry_i[0] = mk(1'b1, 64'h3000);
    fifo_entry_i[1] = mk(1'b1, 64'h3004);
    tick();
    fifo_entry_i[0] = mk(1'b1, 64'h3008);
    fifo_entry_i[1] = mk(1'b1, 64'h300c);
    tick();
    checks++;
    if (count_o !== 4'd3 || fifo_entry_o.pc !== 64'h3004) begin
      failures++;
      $display("[TB] FAIL dis_pre: got cnt=%0d pc=%h expected 3 3004", count_o, fifo_entry_o.pc);
    end
    enable_i        = 1'b0;
    fifo_entry_i[0] = mk(1'b1, 64'hbad0);
    fifo_entry_i[1] = mk(1'b1, 64'hbad4);
    tick();
    checks++;
    if (count_o !== 4'd2 || fifo_entry_o.pc !== 64'h3008) begin
      failures++;
      $display("[TB] FAIL dis_1: got cnt=%0d pc=%h expected 2 3008", count_o, fifo_entry_o.pc);
    end
    tick();
    checks++;
    if (count_o !== 4'd1 || fifo_entry_o.pc !== 64'h300c) begin
      failures++;
      $display("[TB] FAIL dis_2: got cnt=%0d pc=%h expected 1 300c", count_o, fifo_entry_o.pc);
    end
    tick();
    checks++;
    if (count_o !== 4'd0 || fifo_entry_o !== '0) begin
      failures++;
      $display("[TB] FAIL dis_3: got cnt=%0d entry=%h expected 0 0", count_o, fifo_entry_o);
    end
    enable_i = 1'b1;
    clear_inputs();
  endtask

  task automatic test_async_reset();
    fifo_entry_i[0] = mk(1'b1, 64'h4000);
    fifo_entry_i[1] = mk(1'b1, 64'h4004);
    tick();
    tick();
    clear_inputs();
    checks++;
    if (count_o !== 4'd3 || fifo_entry_o.valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL arst_pre: got cnt=%0d v=%b expected 3 1", count_o, fifo_entry_o.valid);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (count_o !== 4'd0 || fifo_entry_o !== '0 || stall_o !== 1'b0 || overflow_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL arst_async: got cnt=%0d entry=%h stall=%b ovf=%b expected 0 0 0 0",
               count_o, fifo_entry_o, stall_o, overflow_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    checks++;
    if (count_o !== 4'd0 || fifo_entry_o !== '0) begin
      failures++;
      $display("[TB] FAIL arst_post: got cnt=%0d entry=%h expected 0 0", count_o, fifo_entry_o);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_ni       = 1'b0;
    enable_i     = 1'b1;
    flush_i      = 1'b0;
    fifo_entry_i = '0;
    #12;
    test_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    test_dual_issue();
    test_exception();
    test_compaction();
    test_fill_overflow();
    test_flush();
    test_disable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
